// File: rtl/generador_cubos.sv
// Cube spawner: free-running 16-bit LFSR, frame-tick interval counter, and
// a small FSM that launches the lowest-index idle cube with a one-cycle
// start pulse carrying random x position, speed and colour.
module generador_cubos #(
    parameter int          NUM_CUBOS        = 4,
    parameter int          INTERVALO_FRAMES = 30,
    parameter int          MAX_X_POS        = 451,
    parameter logic [15:0] SEMILLA          = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic [NUM_CUBOS-1:0] cubo_libre,
    output logic [NUM_CUBOS-1:0] start_cubo,
    output logic [8:0]           posicion_x_aleatoria,
    output logic [1:0]           velocidad_cubo,
    output logic [7:0]           color_cubo,
    output logic [7:0]           cubos_lanzados
);

    localparam int CNT_W = (INTERVALO_FRAMES > 1) ? $clog2(INTERVALO_FRAMES) : 1;
    localparam int SEL_W = (NUM_CUBOS > 1) ? $clog2(NUM_CUBOS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INTERVALO_FRAMES - 1);
    localparam logic [8:0]       X_MAX   = 9'(MAX_X_POS);

    typedef enum logic [1:0] {S_ESPERA, S_BUSCAR, S_LANZAR, S_GUARDA} estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [8:0]       x_q, x_d;
    logic [1:0]       v_q, v_d;
    logic [7:0]       c_q, c_d;
    logic [7:0]       lanz_q, lanz_d;

    logic             tick_frame;
    logic             hay_libre;
    logic [SEL_W-1:0] sel_libre;
    logic [8:0]       x_cand;
    logic [1:0]       v_cand;
    logic [7:0]       c_cand;

    // Same instant the cubes step their y position.
    assign tick_frame = (pixel_y == 10'd481) && (pixel_x == 10'd0);

    // LFSR step and the random launch parameters derived from its current value
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // Out-of-range x folds back by 256 so x + 60 still fits in 9 bits.
        x_cand = (lfsr_q[8:0] > X_MAX) ? (lfsr_q[8:0] - 9'd256) : lfsr_q[8:0];
        v_cand = (lfsr_q[10:9] == 2'd0) ? 2'd1 : lfsr_q[10:9];
        c_cand = (lfsr_q[15:8] == 8'h00) ? 8'hFF : lfsr_q[15:8];
    end

    // Priority encoder: lowest-index idle cube wins
    always_comb begin
        hay_libre = |cubo_libre;
        sel_libre = '0;
        for (int i = NUM_CUBOS - 1; i >= 0; i--) begin
            if (cubo_libre[i]) sel_libre = SEL_W'(i);
        end
    end

    // Next-state and datapath update
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        x_d      = x_q;
        v_d      = v_q;
        c_d      = c_q;
        lanz_d   = lanz_q;
        case (estado_q)
            S_ESPERA: begin
                // With enable low the count is held, not cleared.
                if (enable && tick_frame) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d    = '0;
                        estado_d = S_BUSCAR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_BUSCAR: begin
                if (!enable) begin
                    cnt_d    = '0;
                    estado_d = S_ESPERA;
                end else if (hay_libre) begin
                    sel_d    = sel_libre;
                    x_d      = x_cand;
                    v_d      = v_cand;
                    c_d      = c_cand;
                    estado_d = S_LANZAR;
                end
            end
            S_LANZAR: begin
                if (lanz_q != 8'hFF) lanz_d = lanz_q + 8'd1;
                estado_d = S_GUARDA;
            end
            // One-cycle guard lets the launched cube drop its idle flag.
            S_GUARDA: estado_d = S_ESPERA;
            default:  estado_d = S_ESPERA;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= S_ESPERA;
            cnt_q    <= '0;
            lfsr_q   <= SEMILLA;
            sel_q    <= '0;
            x_q      <= 9'd0;
            v_q      <= 2'd1;
            c_q      <= 8'hFF;
            lanz_q   <= 8'd0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            sel_q    <= sel_d;
            x_q      <= x_d;
            v_q      <= v_d;
            c_q      <= c_d;
            lanz_q   <= lanz_d;
        end
    end

    // Launch pulse decoded from registered state so it is one-hot and single-cycle
    always_comb begin
        start_cubo = '0;
        if (estado_q == S_LANZAR) start_cubo = NUM_CUBOS'(1) << sel_q;
    end

    assign posicion_x_aleatoria = x_q;
    assign velocidad_cubo       = v_q;
    assign color_cubo           = c_q;
    assign cubos_lanzados       = lanz_q;

endmodule

// File: tb/tb_generador_cubos.sv
// Directed bench for generador_cubos with a launch scoreboard and LFSR reference model.
module tb_generador_cubos;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [3:0] cubo_libre;
    logic [3:0] start_cubo;
    logic [8:0] posicion_x_aleatoria;
    logic [1:0] velocidad_cubo;
    logic [7:0] color_cubo;
    logic [7:0] cubos_lanzados;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_lanz  = 0;
    logic [3:0] sb[$];

    logic [15:0] m_lfsr, m_prev;

    generador_cubos #(
        .NUM_CUBOS(4), .INTERVALO_FRAMES(2), .MAX_X_POS(451), .SEMILLA(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .cubo_libre(cubo_libre),
        .start_cubo(start_cubo), .posicion_x_aleatoria(posicion_x_aleatoria),
        .velocidad_cubo(velocidad_cubo), .color_cubo(color_cubo),
        .cubos_lanzados(cubos_lanzados)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: m_prev is the value that was current before the last edge
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [8:0] mx(input logic [15:0] l);
        return (l[8:0] > 9'd451) ? l[8:0] - 9'd256 : l[8:0];
    endfunction
    function automatic logic [1:0] mv(input logic [15:0] l);
        return (l[10:9] == 2'd0) ? 2'd1 : l[10:9];
    endfunction
    function automatic logic [7:0] mc(input logic [15:0] l);
        return (l[15:8] == 8'h00) ? 8'hFF : l[15:8];
    endfunction
    function automatic logic [3:0] lowest(input logic [3:0] l);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 3; i >= 0; i--) if (l[i]) r = 4'b0001 << i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        pixel_y = 10'd481;
        pixel_x = 10'd0;
        @(negedge clk);
        pixel_y = 10'd0;
        pixel_x = 10'd5;
    endtask

    task automatic no_start_for(input string tag, input int cycles);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (start_cubo != 4'b0000) hits++;
        end
        chk(tag, hits, 0);
    endtask

    // Wait for the next launch, compare against the scoreboard and the LFSR model
    task automatic wait_launch(input string tag);
        int n;
        logic [3:0] e;
        logic [8:0] xs;
        logic [1:0] vs;
        logic [7:0] cs;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start_cubo == 4'b0000 && n < 20);
        chk({tag, "_latency"}, n, 1);
        e = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
        chk({tag, "_start"}, start_cubo, e);
        chk({tag, "_x"}, posicion_x_aleatoria, mx(m_prev));
        chk({tag, "_v"}, velocidad_cubo, mv(m_prev));
        chk({tag, "_c"}, color_cubo, mc(m_prev));
        chk({tag, "_x_range"}, posicion_x_aleatoria <= 9'd451, 1);
        chk({tag, "_v_nz"}, velocidad_cubo != 2'd0, 1);
        chk({tag, "_c_nz"}, color_cubo != 8'h00, 1);
        xs = posicion_x_aleatoria;
        vs = velocidad_cubo;
        cs = color_cubo;
        if (exp_lanz != 255) exp_lanz++;
        @(negedge clk);
        chk({tag, "_start_off"}, start_cubo, 4'b0000);
        chk({tag, "_stable"}, {posicion_x_aleatoria, velocidad_cubo, color_cubo}, {xs, vs, cs});
        chk({tag, "_count"}, cubos_lanzados, exp_lanz);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; cubo_libre = 4'b0000;
        pixel_x = 10'd5; pixel_y = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst_start", start_cubo, 4'b0000);
        chk("rst_x", posicion_x_aleatoria, 9'd0);
        chk("rst_v", velocidad_cubo, 2'd1);
        chk("rst_c", color_cubo, 8'hFF);
        chk("rst_count", cubos_lanzados, 8'd0);
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        reset = 1'b0;

        // Basic launch to cube 0, then cube 1
        enable = 1'b1; cubo_libre = 4'b1111;
        do_tick();
        do_tick();
        sb.push_back(lowest(cubo_libre));
        wait_launch("first");
        cubo_libre = 4'b1110;
        do_tick();
        do_tick();
        sb.push_back(4'b0010);
        wait_launch("second");

        // No idle cube: spawn stays pending until one frees up
        cubo_libre = 4'b0000;
        do_tick();
        do_tick();
        no_start_for("pending_none", 100);
        cubo_libre = 4'b0100;
        sb.push_back(4'b0100);
        wait_launch("pending");

        // Count held while disabled
        cubo_libre = 4'b1111;
        do_tick();
        enable = 1'b0;
        repeat (5) do_tick();
        enable = 1'b1;
        do_tick();
        sb.push_back(4'b0001);
        wait_launch("held");

        // Disable while searching abandons the spawn and clears the count
        cubo_libre = 4'b0000;
        do_tick();
        do_tick();
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        cubo_libre = 4'b1111;
        do_tick();
        no_start_for("abandon", 10);
        do_tick();
        sb.push_back(4'b0001);
        wait_launch("fresh");

        // Random idle masks, including counter saturation
        for (int k = 0; k < 10000; k++) begin
            cubo_libre = 4'($urandom_range(1, 15));
            do_tick();
            do_tick();
            sb.push_back(lowest(cubo_libre));
            wait_launch("rand");
        end
        chk("saturated", cubos_lanzados, 8'd255);
        chk("sb_empty", sb.size(), 0);

        // Reset while the start pulse is high
        cubo_libre = 4'b1111;
        do_tick();
        do_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start_cubo == 4'b0000 && n < 20);
        chk("midrst_pulse_seen", start_cubo, 4'b0001);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_start", start_cubo, 4'b0000);
        chk("midrst_count", cubos_lanzados, 8'd0);
        chk("midrst_x", posicion_x_aleatoria, 9'd0);
        chk("midrst_v", velocidad_cubo, 2'd1);
        chk("midrst_c", color_cubo, 8'hFF);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_start_after", start_cubo, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
